// File: rtl/cla_pkg.sv
// Shared types and default sizing for the sequential carry-lookahead adder.
package cla_pkg;

    localparam int unsigned CLA_WIDTH = 16;
    localparam int unsigned CLA_SLICE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE-bit carry-lookahead adder built from generate/propagate terms.
module cla_slice
    import cla_pkg::*;
#(
    parameter int unsigned SLICE = CLA_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;

    // Each carry is a flat sum of products over g/p/cin, with no ripple dependency.
    always_comb begin
        logic prod;
        logic term;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < SLICE; i++) begin
            term = 1'b0;
            for (int unsigned j = 0; j <= i; j++) begin
                prod = g[j];
                for (int unsigned k = j + 1; k <= i; k++) begin
                    prod = prod & p[k];
                end
                term = term | prod;
            end
            prod = cin;
            for (int unsigned k = 0; k <= i; k++) begin
                prod = prod & p[k];
            end
            c[i+1] = term | prod;
        end
        sum  = p ^ c[SLICE-1:0];
        cout = c[SLICE];
    end

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle adder: one SLICE-bit lookahead slice per cycle, LSB first, with valid/ready handshakes.
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = CLA_WIDTH,
    parameter int unsigned SLICE = CLA_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned N     = WIDTH / SLICE;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    state_e             state;
    state_e             state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic [SLICE-1:0]   a_sl;
    logic [SLICE-1:0]   b_sl;
    logic [SLICE-1:0]   s_sl;
    logic               c_sl;
    logic               last_c;
    logic [WIDTH-1:0]   sum_upd;

    // Select the active slice and merge its result into the held sum.
    always_comb begin
        int unsigned shamt;
        logic [WIDTH-1:0] mask;
        shamt   = 32'(cnt) * SLICE;
        a_sl    = SLICE'(a_reg >> shamt);
        b_sl    = SLICE'(b_reg >> shamt);
        mask    = WIDTH'({SLICE{1'b1}}) << shamt;
        sum_upd = (sum & ~mask) | (WIDTH'(s_sl) << shamt);
        last_c  = (cnt == CNT_W'(N - 1));
    end

    cla_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry),
        .sum  (s_sl),
        .cout (c_sl)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (in_valid)  state_next = ST_RUN;
            ST_RUN:  if (last_c)    state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they track it cycle-exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == ST_IDLE);
            out_valid <= (state_next == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    sum   <= sum_upd;
                    carry <= c_sl;
                    if (last_c) begin
                        cout <= c_sl;
                        cnt  <= '0;
                    end else begin
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder: directed corner cases plus randomized traffic with output stalls.
module tb_cla_seq_adder;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned SLICE = 4;
    localparam int unsigned N     = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    logic             ready_cmd;
    logic             stall_bit;
    logic             rand_stall;

    int checks   = 0;
    int failures = 0;
    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] exp_v;

    always #5 clk = ~clk;

    assign out_ready = rand_stall ? stall_bit : ready_cmd;

    cla_seq_adder #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic ci);
        return (WIDTH+1)'(x) + (WIDTH+1)'(y) + (WIDTH+1)'(ci);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=event", name);
    endtask

    always @(posedge clk) begin
        #1;
        stall_bit = 1'($urandom_range(0, 1));
    end

    // Monitor: every output handshake pops one expected {cout,sum}.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=0x%0h expected=none", {cout, sum});
            end else begin
                exp_v = exp_q.pop_front();
                chk("result", 32'({cout, sum}), 32'(exp_v));
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci,
                        input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) timeout_fail("in_ready_wait");
        a        = x;
        b        = y;
        cin      = ci;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        cin      = 1'($urandom_range(0, 1));
        if (push) exp_q.push_back(model(x, y, ci));
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) timeout_fail("out_valid_wait");
    endtask

    task automatic release_out();
        @(posedge clk);
        #1;
        ready_cmd = 1'b1;
        @(posedge clk);
        #1;
        ready_cmd = 1'b0;
    endtask

    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
        send(x, y, ci, 1'b1);
        wait_valid();
        release_out();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        int n;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        ready_cmd  = 1'b0;
        rand_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);

        // Latency: out_valid first high N cycles after the input handshake edge.
        send(16'h0001, 16'h0000, 1'b0, 1'b1);
        for (int i = 1; i <= int'(N); i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("latency_cycle%0d", i), 32'(out_valid), (i == int'(N)) ? 32'd1 : 32'd0);
        end
        release_out();

        run_op(16'h00FF, 16'h0001, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0);
        run_op(16'hBBBB, 16'h6666, 1'b1);

        // Stall in DONE while upstream wiggles inputs and in_valid.
        send(16'h1234, 16'h4321, 1'b1, 1'b1);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            a        = WIDTH'($urandom);
            b        = WIDTH'($urandom);
            cin      = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            @(negedge clk);
            chk("hold_sum", 32'(sum), 32'h5556);
            chk("hold_cout", 32'(cout), 32'd0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        ready_cmd = 1'b1;
        @(posedge clk);
        #1;
        ready_cmd = 1'b0;
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);

        // Reset during the second RUN cycle discards the operation.
        send(16'hAAAA, 16'h5555, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = WIDTH'($urandom);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midreset_in_ready", 32'(in_ready), 32'd1);
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_sum", 32'(sum), 32'd0);
        chk("midreset_cout", 32'(cout), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midreset_no_result", 32'(out_valid), 32'd0);
        end

        // Randomized back-to-back traffic with random output stalls.
        rand_stall = 1'b1;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       begin ra = '1; rb = WIDTH'($urandom); end
                1:       begin ra = '1; rb = '1; end
                2:       begin ra = '0; rb = '0; end
                default: begin ra = WIDTH'($urandom); rb = WIDTH'($urandom); end
            endcase
            send(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) timeout_fail("drain_results");
        rand_stall = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cla_seq_adder.md
CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand and sum width; SHALL be a multiple of SLICE.
REQ-002 Parameter SLICE, default 4, bits added per cycle by the carry-lookahead slice.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operands a, b, cin are valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in to bit 0.
REQ-010 out_valid  output  1  sum and cout are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 sum  output  WIDTH  registered result, (a+b+cin) mod 2^WIDTH.
REQ-013 cout  output  1  carry out of bit WIDTH-1.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE; the reset state SHALL be IDLE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Input handshake = in_valid & in_ready at a rising edge; it SHALL capture a, b and cin, clear the slice counter, and go IDLE -> RUN.
REQ-017 Operands SHALL NOT be sampled outside an input handshake; changes to a, b or cin during RUN or DONE SHALL have no effect.
REQ-018 In RUN, slice k (k = 0..N-1, N = WIDTH/SLICE) SHALL add bits [k*SLICE +: SLICE] of the captured a and b plus the carry register; one slice is processed per cycle, LSB slice first.
REQ-019 The carry register SHALL be loaded with cin at the handshake, then with each slice's carry-out.
REQ-020 Each slice sum SHALL be written into the corresponding bits of the sum register; other bits SHALL hold.
REQ-021 The slice counter SHALL be ceil(log2(N)) bits wide, or 1 bit when N = 1; RUN -> DONE SHALL occur at the edge that processes slice N-1, with cout taking that slice's carry-out.
REQ-022 Latency: out_valid SHALL first be 1 exactly N cycles after the input-handshake edge (4 cycles with default parameters).
REQ-023 In DONE, sum, cout and out_valid SHALL hold stable until out_ready = 1; on that edge the FSM SHALL return to IDLE.
REQ-024 A new input SHALL NOT be accepted in the same cycle as the output handshake; throughput is one operation per N+2 cycles with no backpressure.
REQ-025 Wrap-around: overflow beyond WIDTH bits SHALL appear only on cout; sum SHALL wrap modulo 2^WIDTH.
REQ-026 in_valid while not in IDLE SHALL be ignored; the upstream source must hold in_valid until in_ready = 1.

Reset
REQ-027 rst_n = 0 at a rising edge SHALL force IDLE, sum = 0, cout = 0, carry = 0, counter = 0, out_valid = 0 and in_ready = 1 on the next cycle, including from RUN or DONE.
REQ-028 An operation interrupted by reset SHALL be discarded with no result delivered; in_valid SHALL be ignored during any cycle with rst_n = 0.

Structure
REQ-029 The FSM state enum and the default WIDTH and SLICE constants SHALL live in the shared package cla_pkg.
REQ-030 The per-cycle adder SHALL be one combinational sub-module, cla_slice, with SLICE-bit operands, a carry-in, the SLICE-bit sum, a carry-out, and generate/propagate lookahead logic; it SHALL be instantiated exactly once.

Verification
REQ-031 Reset, then a=0x0001, b=0x0000, cin=0 -> sum=0x0001, cout=0, out_valid rises 4 cycles after the handshake.
REQ-032 a=0x00FF, b=0x0001, cin=0 -> sum=0x0100, cout=0; checks carry crossing a slice boundary.
REQ-033 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; and a=0xBBBB, b=0x6666, cin=1 -> sum=0x2222, cout=1.
REQ-034 Hold out_ready=0 for 5 cycles in DONE while driving new a/b values -> sum, cout and out_valid stay stable and in_ready stays 0; raising out_ready -> IDLE on the next cycle.
REQ-035 Assert rst_n=0 during the second RUN cycle -> next cycle in IDLE with sum=0, cout=0, out_valid=0, in_ready=1, and no result delivered.
REQ-036 Randomized back-to-back operations with random out_ready stalls -> every result equals (a+b+cin) split into {cout, sum}.
